// File: rtl/light_monitor.sv
// light_monitor
//   Receive-side checker for the 6-bit traffic-light bus. Registers the bus,
//   decodes each pattern to a phase index and locks onto the P0->P1->P2->P3
//   sequence. While locked it checks the dwell of every phase and latches the
//   first illegal pattern, out-of-order phase or wrong dwell as a fault.
//
// Parameters
//   GREEN_CYC  required dwell of P0/P2 in clk cycles (1..255)
//   YEL_CYC    required dwell of P1/P3 in clk cycles (1..255)
//
// Ports
//   clk       in   system clock, rising edge
//   rst       in   asynchronous reset, active-low
//   light     in   [5:3] NS {R,Y,G}, [2:0] EW {R,Y,G}
//   clr_err   in   pulse, leaves FAULT
//   phase     out  decoded phase of the locked sequence
//   locked    out  1 while in TRACK
//   dwell     out  cycles the current pattern has been held, saturating
//   err_code  out  00 none, 01 illegal, 10 bad sequence, 11 bad dwell
//   fault     out  1 while in FAULT
//   cyc_cnt   out  completed P3->P0 wraps while locked
//
// state  | meaning
// UNLOCK | waiting for a legal Pk -> P(k+1) step, no error checking
// TRACK  | locked to the sequence, checking pattern, order and dwell
// FAULT  | first error latched, waiting for clr_err
module light_monitor #(
  parameter int unsigned GREEN_CYC = 5,
  parameter int unsigned YEL_CYC   = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  light,
  input  logic        clr_err,
  output logic [1:0]  phase,
  output logic        locked,
  output logic [7:0]  dwell,
  output logic [1:0]  err_code,
  output logic        fault,
  output logic [15:0] cyc_cnt
);

  localparam logic [5:0] PAT_P0 = 6'b001_100;
  localparam logic [5:0] PAT_P1 = 6'b010_100;
  localparam logic [5:0] PAT_P2 = 6'b100_001;
  localparam logic [5:0] PAT_P3 = 6'b100_010;

  localparam logic [7:0] GREEN_D = 8'(GREEN_CYC);
  localparam logic [7:0] YEL_D   = 8'(YEL_CYC);

  typedef enum logic [1:0] {
    UNLOCK = 2'd0,
    TRACK  = 2'd1,
    FAULT  = 2'd2
  } state_t;

  state_t     state;
  logic [5:0] light_q;
  logic [5:0] prev_q;

  logic       cur_ok;
  logic [1:0] cur_idx;
  logic       prv_ok;
  logic [1:0] prv_idx;
  logic       changed;
  logic [7:0] dwell_next;
  logic [7:0] exp_dwell;
  logic       too_long;

  // {legal, phase index}
  function automatic logic [2:0] decode(input logic [5:0] p);
    case (p)
      PAT_P0:  decode = 3'b1_00;
      PAT_P1:  decode = 3'b1_01;
      PAT_P2:  decode = 3'b1_10;
      PAT_P3:  decode = 3'b1_11;
      default: decode = 3'b0_00;
    endcase
  endfunction

  always_comb begin
    {cur_ok, cur_idx} = decode(light_q);
    {prv_ok, prv_idx} = decode(prev_q);
    changed    = (light_q != prev_q);
    exp_dwell  = phase[0] ? YEL_D : GREEN_D;
    dwell_next = 8'd1;
    if (!changed)
      dwell_next = (dwell == 8'hFF) ? 8'hFF : dwell + 8'd1;
    // 9-bit compare so a saturated count still reads as too long
    too_long = ({1'b0, dwell} + 9'd1) > {1'b0, exp_dwell};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= UNLOCK;
      light_q  <= '0;
      prev_q   <= '0;
      phase    <= '0;
      locked   <= 1'b0;
      dwell    <= '0;
      err_code <= '0;
      fault    <= 1'b0;
      cyc_cnt  <= '0;
    end else begin
      light_q <= light;
      prev_q  <= light_q;
      dwell   <= dwell_next;
      case (state)
        UNLOCK: begin
          if (changed && cur_ok && prv_ok && (cur_idx == prv_idx + 2'd1)) begin
            state  <= TRACK;
            locked <= 1'b1;
            phase  <= cur_idx;
          end
        end
        TRACK: begin
          if (!cur_ok) begin
            state    <= FAULT;
            locked   <= 1'b0;
            fault    <= 1'b1;
            err_code <= 2'b01;
          end else if (!changed) begin
            if (too_long) begin
              state    <= FAULT;
              locked   <= 1'b0;
              fault    <= 1'b1;
              err_code <= 2'b11;
            end
          end else if (cur_idx != phase + 2'd1) begin
            state    <= FAULT;
            locked   <= 1'b0;
            fault    <= 1'b1;
            err_code <= 2'b10;
          end else if (dwell != exp_dwell) begin
            state    <= FAULT;
            locked   <= 1'b0;
            fault    <= 1'b1;
            err_code <= 2'b11;
          end else begin
            phase <= cur_idx;
            if (cur_idx == 2'd0)
              cyc_cnt <= cyc_cnt + 16'd1;
          end
        end
        FAULT: begin
          // Errors are not checked here, so a clear always wins
          if (clr_err) begin
            state    <= UNLOCK;
            fault    <= 1'b0;
            err_code <= 2'b00;
          end
        end
        default: begin
          state  <= UNLOCK;
          locked <= 1'b0;
          fault  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_light_monitor.sv
// tb_light_monitor
//   Directed test of light_monitor: lock-on and lap counting, dwell, illegal
//   and order faults, clearing, async reset, and a fast-timing instance for
//   cyc_cnt wrap and dwell saturation.
module tb_light_monitor;

  localparam logic [5:0] P0  = 6'b001_100;
  localparam logic [5:0] P1  = 6'b010_100;
  localparam logic [5:0] P2  = 6'b100_001;
  localparam logic [5:0] P3  = 6'b100_010;
  localparam logic [5:0] ILL = 6'b011_100;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [5:0]  light = '0;
  logic        clr_err = 1'b0;
  logic [1:0]  phase;
  logic        locked;
  logic [7:0]  dwell;
  logic [1:0]  err_code;
  logic        fault;
  logic [15:0] cyc_cnt;

  logic [5:0]  light_f = '0;
  logic        clr_f = 1'b0;
  logic [1:0]  phase_f;
  logic        locked_f;
  logic [7:0]  dwell_f;
  logic [1:0]  err_f;
  logic        fault_f;
  logic [15:0] cyc_f;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  light_monitor #(.GREEN_CYC(5), .YEL_CYC(2)) dut (
    .clk(clk), .rst(rst), .light(light), .clr_err(clr_err),
    .phase(phase), .locked(locked), .dwell(dwell), .err_code(err_code),
    .fault(fault), .cyc_cnt(cyc_cnt)
  );

  light_monitor #(.GREEN_CYC(1), .YEL_CYC(1)) dut_f (
    .clk(clk), .rst(rst), .light(light_f), .clr_err(clr_f),
    .phase(phase_f), .locked(locked_f), .dwell(dwell_f), .err_code(err_f),
    .fault(fault_f), .cyc_cnt(cyc_f)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step(input logic [5:0] p);
    light = p;
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [5:0] p, input int n);
    repeat (n) step(p);
  endtask

  task automatic step_f(input logic [5:0] p);
    light_f = p;
    @(posedge clk);
    #1;
  endtask

  task automatic lap();
    hold(P0, 5);
    hold(P1, 2);
    hold(P2, 5);
    hold(P3, 2);
  endtask

  initial begin
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out", 32'({phase, locked, dwell, err_code, fault, cyc_cnt}), 0);
    rst = 1'b1;

    // T1: lock on first P0->P1 step, three laps
    hold(P0, 5);
    step(P1);
    check("t1_not_yet", 32'(locked), 0);
    step(P1);
    check("t1_locked", 32'(locked), 1);
    check("t1_phase", 32'(phase), 1);
    check("t1_dwell", 32'(dwell), 1);
    hold(P2, 5);
    hold(P3, 2);
    lap();
    lap();
    hold(P0, 2);
    check("t1_cyc", 32'(cyc_cnt), 3);
    check("t1_phase0", 32'(phase), 0);
    check("t1_err", 32'(err_code), 0);
    check("t1_dwell0", 32'(dwell), 1);

    // T2: P1 held one cycle too long
    hold(P0, 3);
    check("t2_dwell5", 32'(dwell), 4);
    hold(P1, 3);
    check("t2_no_fault", 32'(fault), 0);
    check("t2_ph1", 32'(phase), 1);
    step(P2);
    check("t2_fault", 32'(fault), 1);
    check("t2_err", 32'(err_code), 3);
    check("t2_phase", 32'(phase), 1);
    check("t2_unlocked", 32'(locked), 0);
    step(ILL);
    step(P3);
    check("t2_first_err", 32'(err_code), 3);
    clr_err = 1'b1;
    step(P3);
    clr_err = 1'b0;
    check("t2_clr", 32'({fault, locked, err_code}), 0);
    check("t2_cyc_kept", 32'(cyc_cnt), 3);
    step(P3);
    step(P0);
    check("t2_still_unlk", 32'(locked), 0);
    step(P0);
    check("t2_relock", 32'({locked, phase}), 32'b1_00);

    // clr_err outside FAULT does nothing
    clr_err = 1'b1;
    step(P0);
    clr_err = 1'b0;
    check("clr_in_track", 32'({locked, fault}), 32'b10);

    // T3: illegal pattern, reported two edges after it is driven
    step(ILL);
    check("t3_pending", 32'(fault), 0);
    step(P0);
    check("t3_fault", 32'({fault, err_code}), 32'b1_01);

    // T4: wrong-order step P1 -> P3
    clr_err = 1'b1;
    step(P0);
    clr_err = 1'b0;
    check("t4_clr", 32'({fault, err_code}), 0);
    step(P0);
    step(P1);
    step(P1);
    check("t4_lock", 32'({locked, phase}), 32'b1_01);
    step(P3);
    check("t4_dwell", 32'({fault, dwell}), 32'h002);
    step(P3);
    check("t4_seq", 32'({fault, err_code}), 32'b1_10);
    clr_err = 1'b1;
    step(P3);
    clr_err = 1'b0;
    check("t4_clr2", 32'({fault, locked}), 0);
    step(P0);
    step(P0);
    check("t4_relock", 32'({locked, phase}), 32'b1_00);
    check("t4_cyc", 32'(cyc_cnt), 3);

    // T6: async reset mid-TRACK, mid-cycle
    step(P0);
    @(posedge clk);
    #3;
    rst = 1'b0;
    #1;
    check("t6_async", 32'({phase, locked, dwell, err_code, fault, cyc_cnt}), 0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    hold(P0, 2);
    step(P1);
    step(P1);
    check("t6_relock", 32'({locked, phase}), 32'b1_01);
    check("t6_cyc", 32'(cyc_cnt), 0);

    // T5: fast instance, dwell saturation while unlocked, cyc_cnt wrap
    repeat (300) step_f(P0);
    check("t5_sat", 32'(dwell_f), 255);
    check("t5_unlk", 32'(locked_f), 0);
    step_f(P1);
    step_f(P2);
    check("t5_lock", 32'({locked_f, phase_f}), 32'b1_01);
    force dut_f.cyc_cnt = 16'hFFFF;
    #1;
    release dut_f.cyc_cnt;
    step_f(P3);
    step_f(P0);
    check("t5_pre", 32'({phase_f, cyc_f}), {14'd0, 2'd3, 16'hFFFF});
    step_f(P1);
    check("t5_wrap", 32'(cyc_f), 0);
    check("t5_ok", 32'({locked_f, phase_f, err_f}), 32'b1_00_00);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
